mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between the icache and the dcache miss/write paths.
//  Accepts one transaction at a time and sequences it onto the memory port:
//   - a line fill: burst of word reads;
//   - a dcache write-through: single word write.
//  Routes returned words, tagged with their word index, to the granted cache.
//  Sits below both cache instances; the caches hold `busy` (stalling the pipeline) until `*_done`.
// PARAMETERS
//  WORDS_PER_LINE  8  16-bit words per cache line (power of 2, 2..16)
//  MEM_LATENCY     4  cycles from mem_enable (read) to matching mem_data_valid (>=1)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  i_req           in   1   icache fill request; level, held until i_done
//  i_addr          in   16  icache miss byte address (any byte in the line)
//  i_fill_valid    out  1   fill_data/fill_word valid for icache this cycle
//  i_done          out  1   1-cycle pulse: icache transaction complete
//  d_req           in   1   dcache request; level, held until d_done
//  d_wr            in   1   1 = single-word write, 0 = line fill; sampled at grant
//  d_addr          in   16  dcache byte address
//  d_wdata         in   16  write data; sampled at grant
//  d_fill_valid    out  1   fill_data/fill_word valid for dcache this cycle
//  d_done          out  1   1-cycle pulse: dcache transaction complete
//  fill_data       out  16  returned word (shared by both caches)
//  fill_word       out  log2(WORDS_PER_LINE)  word index within line of fill_data
//  mem_enable      out  1   memory access strobe
//  mem_wr          out  1   memory write strobe (only with mem_enable)
//  mem_addr        out  16  memory byte address
//  mem_data_in     out  16  memory write data
//  mem_data_out    in   16  memory read data
//  mem_data_valid  in   1   mem_data_out valid this cycle
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, all outputs 0 (incl. fill_data, mem_addr). Memory returns after reset are ignored.
//  - States: IDLE, FILL, DRAIN, WRITE.
//  - IDLE:
//     - d_req outranks i_req (fixed priority).
//     - Winner, address, d_wr and d_wdata are latched at the edge; state becomes WRITE if d_wr=1, else FILL.
//     - mem_data_valid is ignored.
//  - Line base = addr & ~(2*WORDS_PER_LINE-1). Addresses are byte addresses; words step by 2 and wrap within 16 bits.
//  - FILL:
//     - issue_cnt runs 0..W-1; mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt, one per cycle.
//     - After the issue with issue_cnt=W-1 -> DRAIN.
//  - FILL/DRAIN return path:
//     - Each mem_data_valid returns the next word in order: fill_data = mem_data_out, fill_word = ret_cnt.
//     - The granted requester's *_fill_valid is asserted and ret_cnt increments.
//  - DRAIN: mem_enable=0. The return with ret_cnt=W-1 pulses *_done in that same cycle -> IDLE.
//  - WRITE: one cycle; mem_enable=1, mem_wr=1, mem_addr = d_addr & 16'hFFFE, mem_data_in = d_wdata. d_done=1 that cycle -> IDLE.
//  - Latency (req high in IDLE cycle t):
//     - fill: first address at t+1, word k valid at t+1+k+MEM_LATENCY, done at t+W+MEM_LATENCY.
//     - write: done at t+1.
//  - Requester must drop req on the edge ending its done cycle, else it is re-arbitrated as a new request.
//  - Req deasserted mid-transaction: the transaction still runs to completion; done and fill_valid still pulse.
//  - Requests arriving while not IDLE wait; the loser of a simultaneous request is served next.
//  - Unsolicited mem_data_valid in IDLE/WRITE: ignored, no output.
//  - Outputs are registered-state decodes; no combinational path from i_req/d_req to mem_*.
// CONFIGURATION
//  MEM_ARB_RR_EN:
//   - Defined: round-robin grant. A 1-bit last-grant register is set on every grant (reset value: icache).
//     On a simultaneous request, the requester not granted last wins.
//   - Undefined: fixed dcache priority as above, no last-grant register.
// TESTING
//  1. rst pulse mid-FILL -> state IDLE, all outputs 0 asynchronously; the in-flight mem_data_valid after release gives no fill_valid.
//  2. i_req=1, i_addr=0x1236 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; 8 i_fill_valid with fill_word 0..7; i_done at t+12.
//  3. d_req=1, d_wr=1, d_addr=0x0043, d_wdata=0xBEEF -> one cycle mem_enable=1, mem_wr=1, mem_addr=0x0042, data 0xBEEF; d_done at t+1.
//  4. i_req and d_req (fill, 0x2000) same cycle -> dcache fill first, d_done at t+12; icache fill begins t+14, i_done t+25. With MEM_ARB_RR_EN, dcache is still first after reset.
//  5. i_addr=0xFFF8 fill -> addresses 0xFFF0..0xFFFE, no wrap past line; 8 words returned.
//  6. d_req dropped 3 cycles into a fill -> all 8 d_fill_valid and d_done still delivered; next IDLE grants pending i_req.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache line fills and dcache write-throughs onto one memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the dcache has fixed priority.
module mem_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int MEM_LATENCY    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_req,
    input  logic [15:0]                       i_addr,
    output logic                              i_fill_valid,
    output logic                              i_done,
    input  logic                              d_req,
    input  logic                              d_wr,
    input  logic [15:0]                       d_addr,
    input  logic [15:0]                       d_wdata,
    output logic                              d_fill_valid,
    output logic                              d_done,
    output logic [15:0]                       fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
    output logic                              mem_enable,
    output logic                              mem_wr,
    output logic [15:0]                       mem_addr,
    output logic [15:0]                       mem_data_in,
    input  logic [15:0]                       mem_data_out,
    input  logic                              mem_data_valid
);

    localparam int              WW        = $clog2(WORDS_PER_LINE);
    localparam logic [WW-1:0]   LAST_WORD = WW'(WORDS_PER_LINE - 1);
    localparam logic [15:0]     LINE_MASK = 16'(2 * WORDS_PER_LINE - 1);

    if (MEM_LATENCY < 1 || WORDS_PER_LINE < 2 || WORDS_PER_LINE > 16) begin : g_param_check
        $error("mem_arbiter: unsupported WORDS_PER_LINE/MEM_LATENCY");
    end

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, WRITE} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;     // 1 = dcache owns the transaction
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [WW-1:0]   issue_q, issue_d;
    logic [WW-1:0]   ret_q, ret_d;
    logic            grant_dcache;
    logic            ret_fire;
    logic            last_ret;
    logic [15:0]     line_base;
`ifdef MEM_ARB_RR_EN
    logic            last_q, last_d;       // 1 = dcache was granted last
`endif

    assign line_base = addr_q & ~LINE_MASK;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        issue_d      = issue_q;
        ret_d        = ret_q;
        i_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_fill_valid = 1'b0;
        d_done       = 1'b0;
        fill_data    = 16'h0000;
        fill_word    = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
`ifdef MEM_ARB_RR_EN
        last_d       = last_q;
        grant_dcache = d_req && !(i_req && last_q);
`else
        grant_dcache = d_req;
`endif
        ret_fire = mem_data_valid && (state_q == FILL || state_q == DRAIN);
        last_ret = ret_fire && (state_q == DRAIN) && (ret_q == LAST_WORD);

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d = grant_dcache;
                    addr_d  = grant_dcache ? d_addr : i_addr;
                    wdata_d = grant_dcache ? d_wdata : wdata_q;
                    issue_d = '0;
                    ret_d   = '0;
                    state_d = (grant_dcache && d_wr) ? WRITE : FILL;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant_dcache;
`endif
                end
            end
            FILL: begin
                mem_enable = 1'b1;
                mem_addr   = line_base + 16'({issue_q, 1'b0});
                issue_d    = issue_q + 1'b1;
                if (issue_q == LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_ret) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q & 16'hFFFE;
                mem_data_in = wdata_q;
                d_done      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Returns arrive strictly in issue order, so a running count is the word index.
        if (ret_fire) begin
            ret_d        = ret_q + 1'b1;
            fill_data    = mem_data_out;
            fill_word    = ret_q;
            i_fill_valid = !owner_q;
            d_fill_valid = owner_q;
        end
        if (last_ret) begin
            i_done = !owner_q;
            d_done = owner_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: latency-modelled memory, issue/fill scoreboards,
// a table of single transactions and hand-written multi-cycle corner cases.
module tb_mem_arbiter;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [15:0]   i_addr, d_addr, d_wdata;
    logic          i_fill_valid, i_done, d_fill_valid, d_done;
    logic [15:0]   fill_data;
    logic [WW-1:0] fill_word;
    logic          mem_enable, mem_wr;
    logic [15:0]   mem_addr, mem_data_in, mem_data_out;
    logic          mem_data_valid;
    logic          inj_valid;

    typedef struct { logic [15:0] addr; logic wr; logic [15:0] data; } issue_t;
    typedef struct { logic owner; logic [WW-1:0] word; logic [15:0] data; } fill_t;
    typedef struct { logic use_d; logic wr; logic [15:0] addr; logic [15:0] wdata; int exp_lat; } vec_t;

    issue_t exp_issue[$];
    fill_t  exp_fill[$];
    vec_t   vecs[6];
    int     total = 0;
    int     bad   = 0;

    mem_arbiter #(.WORDS_PER_LINE(W), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_fill_valid(d_fill_valid), .d_done(d_done),
        .fill_data(fill_data), .fill_word(fill_word),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: read issued in cycle c returns in cycle c+L; not reset, like real memory.
    logic [L:1]  pv = '0;
    logic [15:0] pd [1:L] = '{default: 16'h0000};
    always @(posedge clk) begin
        pv[1] <= mem_enable && !mem_wr;
        pd[1] <= mem_word(mem_addr);
        for (int k = 2; k <= L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign mem_data_valid = pv[L] | inj_valid;
    assign mem_data_out   = pd[L];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_fill(input logic owner, input logic [15:0] addr);
        logic [15:0] base, a;
        base = addr & ~16'(2 * W - 1);
        for (int k = 0; k < W; k++) begin
            a = base + 16'(2 * k);
            exp_issue.push_back('{a, 1'b0, 16'h0000});
            exp_fill.push_back('{owner, WW'(k), mem_word(a)});
        end
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
        exp_issue.push_back('{addr & 16'hFFFE, 1'b1, data});
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        issue_t ie;
        fill_t  fe;
        if (mem_enable) begin
            if (exp_issue.size() == 0) begin
                total++; bad++;
                $display("FAIL issue_unexpected: got addr 0x%0h, expected no access", mem_addr);
            end else begin
                ie = exp_issue.pop_front();
                check("issue_addr", mem_addr, ie.addr);
                check("issue_wr", mem_wr, ie.wr);
                if (ie.wr) check("issue_wdata", mem_data_in, ie.data);
            end
        end
        if (i_fill_valid || d_fill_valid) begin
            if (exp_fill.size() == 0) begin
                total++; bad++;
                $display("FAIL fill_unexpected: got word %0d data 0x%0h, expected no fill", fill_word, fill_data);
            end else begin
                fe = exp_fill.pop_front();
                check("fill_both", i_fill_valid & d_fill_valid, 0);
                check("fill_owner", d_fill_valid, fe.owner);
                check("fill_word", fill_word, fe.word);
                check("fill_data", fill_data, fe.data);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_mem"}, {mem_enable, mem_wr, mem_addr, mem_data_in}, 0);
        check({name, "_fill"}, {i_fill_valid, d_fill_valid, fill_data, fill_word}, 0);
        check({name, "_done"}, {i_done, d_done}, 0);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int cyc;
        bit seen;
        @(negedge clk);
        if (v.use_d) begin
            d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
            if (v.wr) push_write(v.addr, v.wdata);
            else push_fill(1'b1, v.addr);
        end else begin
            i_addr = v.addr; i_req = 1'b1;
            push_fill(1'b0, v.addr);
        end
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (v.use_d ? d_done : i_done) seen = 1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check({name, "_done_latency"}, cyc, v.exp_lat);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc, d_at, i_at, nfv;
        vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 12};
        vecs[1] = '{1'b1, 1'b1, 16'h0043, 16'hBEEF, 1};
        vecs[2] = '{1'b0, 1'b0, 16'hFFF8, 16'h0000, 12};
        vecs[3] = '{1'b1, 1'b0, 16'h2001, 16'h0000, 12};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1};
        vecs[5] = '{1'b0, 1'b0, 16'h000E, 16'h0000, 12};

        rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; inj_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        inj_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // done pulse is one cycle wide
        @(negedge clk);
        check("done_pulse_width", {i_done, d_done, mem_enable}, 0);

        // Async reset mid-fill; in-flight returns after release must be dropped.
        @(negedge clk);
        i_addr = 16'h4000; i_req = 1'b1; push_fill(1'b0, 16'h4000);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1; i_req = 1'b0;
        #1 check_all_zero("async_reset");
        exp_issue.delete(); exp_fill.delete();
        @(negedge clk); rst = 1'b0;
        nfv = 0;
        repeat (L + 4) begin
            @(negedge clk);
            if (i_fill_valid || d_fill_valid || mem_enable) nfv++;
        end
        check("post_reset_quiet", nfv, 0);

        // Simultaneous requests: dcache fill served first, icache next.
        @(negedge clk);
        i_addr = 16'h3000; d_addr = 16'h2000; d_wr = 1'b0; i_req = 1'b1; d_req = 1'b1;
        push_fill(1'b1, 16'h2000); push_fill(1'b0, 16'h3000);
        cyc = 0; d_at = -1; i_at = -1;
        while (i_at < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 13) check("sim_gap_idle", mem_enable, 0);
            if (cyc == 14) check("sim_icache_start", {mem_enable, mem_addr}, {1'b1, 16'h3000});
            if (d_done) begin d_at = cyc; d_req = 1'b0; end
            if (i_done) begin i_at = cyc; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("sim_d_done_at", d_at, 12);
        check("sim_i_done_at", i_at, 25);

        // d_req dropped mid-fill while i_req waits.
        @(negedge clk);
        d_addr = 16'h5000; d_wr = 1'b0; d_req = 1'b1; push_fill(1'b1, 16'h5000);
        cyc = 0; d_at = -1; i_at = -1; nfv = 0;
        while (i_at < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin i_addr = 16'h6000; i_req = 1'b1; push_fill(1'b0, 16'h6000); end
            if (cyc == 3) d_req = 1'b0;
            if (d_fill_valid) nfv++;
            if (d_done) d_at = cyc;
            if (i_done) begin i_at = cyc; i_req = 1'b0; end
        end
        i_req = 1'b0;
        check("drop_d_fill_count", nfv, 8);
        check("drop_d_done_at", d_at, 12);
        check("drop_i_done_at", i_at, 25);

        // Unsolicited memory returns in IDLE and WRITE produce nothing.
        @(negedge clk);
        inj_valid = 1'b1;
        #1 check("unsol_idle", {i_fill_valid, d_fill_valid, i_done, d_done, fill_data}, 0);
        @(negedge clk);
        d_addr = 16'h0101; d_wdata = 16'h7777; d_wr = 1'b1; d_req = 1'b1;
        push_write(16'h0101, 16'h7777);
        @(negedge clk);
        check("unsol_write_fill", {i_fill_valid, d_fill_valid, fill_data}, 0);
        check("unsol_write_done", d_done, 1);
        d_req = 1'b0; inj_valid = 1'b0;
        @(negedge clk);

        check("issue_queue_empty", exp_issue.size(), 0);
        check("fill_queue_empty", exp_fill.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
